// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
// Sequenced ALU control decoder. Turns (aluOP, funct3, funct7) into an ALU
// operation code and hands the result over through a valid/ready handshake.
// Single-cycle ops appear one cycle after accept. MUL* and DIV*/REM* ops hold
// the result back for a configurable latency so that valid_o lines up with a
// multicycle datapath.
//
// Ports
//   clk_i      sole clock, rising edge
//   rst_ni     asynchronous active-low reset
//   valid_i    decode request present
//   ready_o    request accepted when valid_i && ready_o
//   aluOP_i    00 ld/st, 01 branch, 10 R-type, 11 I-type
//   func3_i    instruction funct3
//   func7_i    instruction funct7 (imm[11:5] for I-type)
//   valid_o    ALUCtrl_o / illegal_o / multi_o valid
//   ready_i    consumer takes the result when valid_o && ready_i
//   ALUCtrl_o  ALU operation code, zero-extended to CTRL_W
//   multi_o    current op is multicycle (MUL*/DIV*/REM*)
//   busy_o     multicycle latency count in progress
//   illegal_o  unsupported encoding, qualified by valid_o
module alu_ctrl_seq #(
    parameter int CTRL_W  = 5,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        aluOP_i,
    input  logic [2:0]        func3_i,
    input  logic [6:0]        func7_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              multi_o,
    output logic              busy_o,
    output logic              illegal_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [4:0] OP_AND  = 5'h00;
    localparam logic [4:0] OP_OR   = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_XOR  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h06;
    localparam logic [4:0] OP_SLT  = 5'h07;
    localparam logic [4:0] OP_SLTU = 5'h08;
    localparam logic [4:0] OP_SLL  = 5'h09;
    localparam logic [4:0] OP_SRL  = 5'h0A;
    localparam logic [4:0] OP_SRA  = 5'h0B;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        MC,
        OUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       base_code;
    logic [4:0]       dec_code;
    logic             dec_illegal;
    logic             dec_mul;
    logic             dec_div;
    logic [CNT_W-1:0] lat_load;
    logic             accept;

    // Plain integer ops selected by funct3, shared by R-type (funct7=0) and I-type.
    always_comb begin
        base_code = OP_ADD;
        case (func3_i)
            3'b000: base_code = OP_ADD;
            3'b001: base_code = OP_SLL;
            3'b010: base_code = OP_SLT;
            3'b011: base_code = OP_SLTU;
            3'b100: base_code = OP_XOR;
            3'b101: base_code = OP_SRL;
            3'b110: base_code = OP_OR;
            3'b111: base_code = OP_AND;
            default: base_code = OP_ADD;
        endcase
    end

    // Full decode. Illegal encodings fall back to the ADD code with the illegal
    // flag set; they never count as multicycle. The M-extension codes are
    // 0x10 + funct3, so funct3[2] separates MUL* from DIV*/REM*.
    always_comb begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (aluOP_i)
            2'b00: dec_code = OP_ADD;
            2'b01: dec_code = OP_SUB;
            2'b10: begin
                if (func7_i == F7_BASE) begin
                    dec_code = base_code;
                end else if (func7_i == F7_ALT && func3_i == 3'b000) begin
                    dec_code = OP_SUB;
                end else if (func7_i == F7_ALT && func3_i == 3'b101) begin
                    dec_code = OP_SRA;
                end else if (func7_i == F7_MULDIV && EN_M != 0) begin
                    dec_code = {2'b10, func3_i};
                    dec_mul  = ~func3_i[2];
                    dec_div  = func3_i[2];
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                // I-type: funct7 is immediate bits except for the shift encodings.
                if (func3_i == 3'b001 && func7_i != F7_BASE) begin
                    dec_illegal = 1'b1;
                end else if (func3_i == 3'b101) begin
                    if (func7_i == F7_BASE) begin
                        dec_code = OP_SRL;
                    end else if (func7_i == F7_ALT) begin
                        dec_code = OP_SRA;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    dec_code = base_code;
                end
            end
        endcase
    end

    // Remaining cycles to wait after accept; zero means the result goes
    // straight to OUT.
    always_comb begin
        lat_load = '0;
        if (dec_mul) begin
            lat_load = MUL_LOAD;
        end else if (dec_div) begin
            lat_load = DIV_LOAD;
        end
    end

    // In OUT a new request may be taken in the same cycle the old result leaves.
    assign ready_o = (state == IDLE) || (state == OUT && ready_i);
    assign accept  = valid_i && ready_o;

    // Sequencer. Outputs are registered alongside the state so they only change
    // on accept, on the MC->OUT transition or when the result is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            valid_o   <= 1'b0;
            ALUCtrl_o <= '0;
            multi_o   <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (accept) begin
            ALUCtrl_o <= CTRL_W'(dec_code);
            multi_o   <= dec_mul | dec_div;
            illegal_o <= dec_illegal;
            cnt       <= lat_load;
            if (lat_load != '0) begin
                state   <= MC;
                busy_o  <= 1'b1;
                valid_o <= 1'b0;
            end else begin
                state   <= OUT;
                busy_o  <= 1'b0;
                valid_o <= 1'b1;
            end
        end else begin
            case (state)
                MC: begin
                    if (cnt == CNT_ONE) begin
                        state   <= OUT;
                        cnt     <= '0;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
// Self-checking bench for alu_ctrl_seq. A second instance built with EN_M=0
// shares the decode inputs but has its own handshake signals. Expected results
// come from a table-driven model of the instruction encoding and a latency rule.
module tb_alu_ctrl_seq;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    typedef struct {
        logic [4:0] code;
        logic       ill;
        logic       multi;
        int         lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_i = 1'b0;
    logic              valid_b = 1'b0;
    logic              ready_b = 1'b0;
    logic [1:0]        alu_op = 2'b00;
    logic [2:0]        func3 = 3'b000;
    logic [6:0]        func7 = 7'b0000000;

    logic              ready_o, valid_o, multi_o, busy_o, illegal_o;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              ready_ob, valid_ob, multi_ob, busy_ob, illegal_ob;
    logic [CTRL_W-1:0] alu_ctrl_b;

    logic [9:0]        obs;
    logic [9:0]        obs_b;

    int checks = 0;
    int passes = 0;

    // Observed output bundle: {valid, multi, busy, illegal, ready, ALUCtrl}.
    assign obs   = {valid_o, multi_o, busy_o, illegal_o, ready_o, alu_ctrl};
    assign obs_b = {valid_ob, multi_ob, busy_ob, illegal_ob, ready_ob, alu_ctrl_b};

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .CTRL_W(CTRL_W), .EN_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .aluOP_i(alu_op), .func3_i(func3), .func7_i(func7), .valid_o(valid_o),
        .ready_i(ready_i), .ALUCtrl_o(alu_ctrl), .multi_o(multi_o),
        .busy_o(busy_o), .illegal_o(illegal_o)
    );

    alu_ctrl_seq #(
        .CTRL_W(CTRL_W), .EN_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut_nom (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .ready_o(ready_ob),
        .aluOP_i(alu_op), .func3_i(func3), .func7_i(func7), .valid_o(valid_ob),
        .ready_i(ready_b), .ALUCtrl_o(alu_ctrl_b), .multi_o(multi_ob),
        .busy_o(busy_ob), .illegal_o(illegal_ob)
    );

    // Reference decode straight from the encoding tables.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic en_m);
        exp_t       e;
        logic [4:0] base_tab [8];
        base_tab = '{5'h02, 5'h09, 5'h07, 5'h08, 5'h03, 5'h0A, 5'h01, 5'h00};
        e.code  = 5'h02;
        e.ill   = 1'b0;
        e.multi = 1'b0;
        e.lat   = 1;
        if (op == 2'd1) begin
            e.code = 5'h06;
        end else if (op == 2'd2) begin
            if (f7 == 7'h00) e.code = base_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.code = 5'h06;
            else if (f7 == 7'h20 && f3 == 3'd5) e.code = 5'h0B;
            else if (f7 == 7'h01 && en_m) begin
                e.code  = 5'h10 + 5'(f3);
                e.multi = 1'b1;
                e.lat   = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
            end else e.ill = 1'b1;
        end else if (op == 2'd3) begin
            if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
            else if (f3 == 3'd5) begin
                if (f7 == 7'h00) e.code = 5'h0A;
                else if (f7 == 7'h20) e.code = 5'h0B;
                else e.ill = 1'b1;
            end else e.code = base_tab[f3];
        end
        return e;
    endfunction

    function automatic logic [9:0] pack(input logic v, input logic m, input logic b,
                                        input logic i, input logic r, input logic [4:0] c);
        return {v, m, b, i, r, c};
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0: return 7'h00;
            1: return 7'h20;
            2: return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00))
            $display("[TB] FAIL reset_state: got %h expected %h", obs, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00));
        else passes++;
        checks++;
        if (obs_b !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00))
            $display("[TB] FAIL reset_state_nom: got %h expected %h", obs_b, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00));
        else passes++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00))
            $display("[TB] FAIL reset_release: got %h expected %h", obs, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00));
        else passes++;
    endtask

    task automatic test_sub();
        alu_op = 2'b10; func3 = 3'b000; func7 = 7'b0100000;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h06))
            $display("[TB] FAIL sub_result: got %h expected %h", obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h06));
        else passes++;
        tick();
        checks++;
        if (obs[9] !== 1'b0) $display("[TB] FAIL sub_drop: got valid %b expected 0", obs[9]);
        else passes++;
    endtask

    task automatic test_div();
        alu_op = 2'b10; func3 = 3'b100; func7 = 7'b0000001;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        for (int k = 0; k < DIV_LAT - 1; k++) begin
            checks++;
            if (obs !== pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h14))
                $display("[TB] FAIL div_busy_%0d: got %h expected %h", k + 1, obs, pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h14));
            else passes++;
            // Noise on the request side must be ignored while counting.
            valid_i = (k == DIV_LAT - 2) ? 1'b0 : 1'($urandom);
            ready_i = (k == DIV_LAT - 2) ? 1'b0 : 1'($urandom);
            alu_op  = 2'($urandom);
            func3   = 3'($urandom);
            func7   = pick_f7();
            tick();
        end
        checks++;
        if (obs !== pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h14))
            $display("[TB] FAIL div_result: got %h expected %h", obs, pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h14));
        else passes++;
        ready_i = 1'b1;
        tick();
        checks++;
        if (obs[9] !== 1'b0) $display("[TB] FAIL div_drop: got valid %b expected 0", obs[9]);
        else passes++;
    endtask

    task automatic test_hold();
        alu_op = 2'b00; func3 = 3'($urandom); func7 = 7'($urandom);
        valid_i = 1'b1; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h02))
                $display("[TB] FAIL hold_%0d: got %h expected %h", k, obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h02));
            else passes++;
            alu_op = 2'($urandom); func3 = 3'($urandom); func7 = pick_f7();
            tick();
        end
        alu_op = 2'b10; func3 = 3'b100; func7 = 7'b0000000;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02))
            $display("[TB] FAIL hold_ready: got %h expected %h", obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02));
        else passes++;
        tick();
        valid_i = 1'b0;
        checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h03))
            $display("[TB] FAIL hold_b2b_xor: got %h expected %h", obs, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h03));
        else passes++;
        tick();
        checks++;
        if (obs[9] !== 1'b0) $display("[TB] FAIL hold_drop: got valid %b expected 0", obs[9]);
        else passes++;
    endtask

    task automatic test_illegal();
        alu_op = 2'b11; func3 = 3'b101; func7 = 7'b0100001;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++;
        if (obs !== pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h02))
            $display("[TB] FAIL illegal_itype: got %h expected %h", obs, pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h02));
        else passes++;
        tick();
        alu_op = 2'b10; func3 = 3'($urandom); func7 = 7'b0000001;
        valid_b = 1'b1; ready_b = 1'b1;
        tick();
        valid_b = 1'b0;
        checks++;
        if (obs_b !== pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h02))
            $display("[TB] FAIL illegal_no_m: got %h expected %h", obs_b, pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h02));
        else passes++;
        tick();
        checks++;
        if (obs_b[9] !== 1'b0) $display("[TB] FAIL illegal_no_m_drop: got valid %b expected 0", obs_b[9]);
        else passes++;
    endtask

    task automatic test_reset_abort();
        alu_op = 2'b10; func3 = 3'b100; func7 = 7'b0000001;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00))
            $display("[TB] FAIL abort_reset: got %h expected %h", obs, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00));
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", ready_o);
        else passes++;
        for (int k = 0; k < DIV_LAT + 8; k++) begin
            tick();
            checks++;
            if (obs[9] !== 1'b0) $display("[TB] FAIL abort_no_result_%0d: got valid %b expected 0", k, obs[9]);
            else passes++;
        end
    endtask

    task automatic test_stream();
        exp_t       q [8];
        logic [1:0] ops [8];
        logic [2:0] f3s [8];
        logic [6:0] f7s [8];
        for (int k = 0; k < 8; k++) begin
            do begin
                ops[k] = 2'($urandom);
                f3s[k] = 3'($urandom);
                f7s[k] = pick_f7();
                q[k]   = model(ops[k], f3s[k], f7s[k], 1'b1);
            end while (q[k].lat != 1);
        end
        ready_i = 1'b1;
        valid_i = 1'b1;
        alu_op = ops[0]; func3 = f3s[0]; func7 = f7s[0];
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (obs !== pack(1'b1, 1'b0, 1'b0, q[k].ill, 1'b1, q[k].code))
                $display("[TB] FAIL stream_%0d: got %h expected %h", k, obs, pack(1'b1, 1'b0, 1'b0, q[k].ill, 1'b1, q[k].code));
            else passes++;
            if (k < 7) begin
                alu_op = ops[k + 1]; func3 = f3s[k + 1]; func7 = f7s[k + 1];
            end else begin
                valid_i = 1'b0;
            end
        end
        tick();
        checks++;
        if (obs[9] !== 1'b0) $display("[TB] FAIL stream_drop: got valid %b expected 0", obs[9]);
        else passes++;
    endtask

    task automatic test_random();
        exp_t e;
        int   stalls;
        for (int n = 0; n < 24; n++) begin
            alu_op = 2'($urandom); func3 = 3'($urandom); func7 = pick_f7();
            e = model(alu_op, func3, func7, 1'b1);
            valid_i = 1'b1; ready_i = 1'($urandom);
            tick();
            valid_i = 1'b0;
            for (int j = 1; j < e.lat; j++) begin
                checks++;
                if (obs !== pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e.code))
                    $display("[TB] FAIL rnd_busy_%0d_%0d: got %h expected %h", n, j, obs, pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e.code));
                else passes++;
                valid_i = 1'($urandom); ready_i = 1'($urandom);
                alu_op = 2'($urandom); func3 = 3'($urandom); func7 = pick_f7();
                tick();
            end
            valid_i = 1'b0;
            stalls = $urandom_range(0, 3);
            for (int s = 0; s < stalls; s++) begin
                ready_i = 1'b0;
                #1;
                checks++;
                if (obs !== pack(1'b1, e.multi, 1'b0, e.ill, 1'b0, e.code))
                    $display("[TB] FAIL rnd_stall_%0d: got %h expected %h", n, obs, pack(1'b1, e.multi, 1'b0, e.ill, 1'b0, e.code));
                else passes++;
                tick();
            end
            ready_i = 1'b1;
            #1;
            checks++;
            if (obs !== pack(1'b1, e.multi, 1'b0, e.ill, 1'b1, e.code))
                $display("[TB] FAIL rnd_result_%0d: got %h expected %h", n, obs, pack(1'b1, e.multi, 1'b0, e.ill, 1'b1, e.code));
            else passes++;
            tick();
            checks++;
            if (obs[9] !== 1'b0) $display("[TB] FAIL rnd_drop_%0d: got valid %b expected 0", n, obs[9]);
            else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sub();
        test_div();
        test_hold();
        test_illegal();
        test_stream();
        test_random();
        test_reset_abort();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
